// File: rtl/signex_pipe_if.sv
// Handshake bundle for signex_pipe: a request channel (in_*) carrying an
// immediate plus extension mode and shift amount, and a result channel
// (out_*) carrying the extended, shifted value. Both use valid/ready.
// master: the environment that issues requests and consumes results.
// slave : the signex_pipe block.
interface signex_pipe_if #(
    parameter int IN_W  = 13,
    parameter int OUT_W = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_zext;
    logic [1:0]       in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_zext, in_shamt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_zext, in_shamt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/signex_pipe.sv
// signex_pipe: one-stage pipelined immediate extender.
// result = (in_zext ? zero-extend : sign-extend)(in_data to OUT_W) << in_shamt,
// truncated to OUT_W bits, registered into a valid/ready output stage.
// Reset is synchronous and active-low; in_ready is forced low while rst_n=0.
//
// Build option SIGNEX_PIPE_SKID_EN:
//   undefined - single output register, in_ready = !out_valid || out_ready
//               (combinational from out_ready).
//   defined   - adds one skid entry so in_ready comes from a register and
//               has no combinational path from out_ready.
// Both builds deliver the same result sequence for the same accepted input.
module signex_pipe #(
    parameter int IN_W  = 13,
    parameter int OUT_W = 32
) (
    input logic         clk,
    input logic         rst_n,
    signex_pipe_if.slave bus
);

    // ------------------------------------------------------------------
    // Datapath: extension followed by the left shift
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] ext_val;
    logic [OUT_W-1:0] new_result;

    generate
        if (OUT_W > IN_W) begin : g_ext
            logic fill_bit;
            // Upper bits replicate the sign bit only in sign mode.
            assign fill_bit = ~bus.in_zext & bus.in_data[IN_W-1];
            assign ext_val  = {{(OUT_W - IN_W){fill_bit}}, bus.in_data};
        end else begin : g_noext
            // Equal widths: nothing to extend, mode has no effect.
            assign ext_val = bus.in_data;
        end
    endgenerate

    // Bits shifted past OUT_W-1 fall off; vacated low bits fill with 0.
    assign new_result = ext_val << bus.in_shamt;

    // ------------------------------------------------------------------
    // Output stage (and optional skid entry)
    // ------------------------------------------------------------------
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             accept;
    logic             drain;

    assign drain = out_valid_q & bus.out_ready;

`ifdef SIGNEX_PIPE_SKID_EN

    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic             load_out;

    // in_ready depends only on the skid register (and reset), never on
    // out_ready, which breaks the ready path between producer and consumer.
    assign bus.in_ready = rst_n & ~skid_valid_q;
    assign accept       = bus.in_valid & bus.in_ready;
    // The output register can take a new value when empty or draining.
    assign load_out     = ~out_valid_q | bus.out_ready;

    // Next-state: skid entry has priority into the output to keep order.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (load_out) begin
            if (skid_valid_q) begin
                // in_ready is low while the skid is full, so no accept here.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = new_result;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output is stalled: park the new result in the skid entry.
            skid_valid_d = 1'b1;
            skid_data_d  = new_result;
        end
    end

    // State registers with synchronous clear of both entries.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            // NOTE: the data registers are cleared too: out_data is visible
            // and must read 0 after reset, and a stale skid value must not
            // survive into a later transfer.
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`else

    // Accept whenever the output register is empty or drains this cycle.
    assign bus.in_ready = rst_n & (~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // Next-state: load on accept, otherwise empty out on drain.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = new_result;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            // NOTE: out_data is visible and must read 0 after reset, so the
            // data register is cleared along with the valid flag.
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_signex_pipe.sv
// Self-checking bench for signex_pipe. Two instances: a 13->32 extender
// (main target) and a 32->32 one for the truncation corner. Works in both
// builds; the only build-dependent expectation is when in_ready falls under
// backpressure.
module tb_signex_pipe;

    localparam int IN_W   = 13;
    localparam int OUT_W  = 32;
    localparam int WIDE_W = 32;
`ifdef SIGNEX_PIPE_SKID_EN
    localparam int BP_ACCEPTS = 2;
`else
    localparam int BP_ACCEPTS = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    signex_pipe_if #(.IN_W(IN_W),   .OUT_W(OUT_W)) ifa ();
    signex_pipe_if #(.IN_W(WIDE_W), .OUT_W(OUT_W)) ifb ();

    signex_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    signex_pipe #(.IN_W(WIDE_W), .OUT_W(OUT_W)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          wide;
        logic [31:0] data;
        bit          zext;
        logic [1:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the immediate's numeric value.
    function automatic logic [31:0] model(input logic [31:0] data, input int in_w,
                                          input bit zext, input int shamt);
        longint v;
        v = longint'(data) & ((longint'(1) << in_w) - 1);
        if (!zext && ((v >> (in_w - 1)) & 1) == 1)
            v = v - (longint'(1) << in_w);
        v = v * (longint'(1) << shamt);
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on dut_a with scoreboard: drains are compared against the
    // queue, accepts push the model's result.
    task automatic step_a(input bit v, input logic [12:0] d, input bit z,
                          input logic [1:0] s, input bit ordy, input string tag,
                          output bit acc, output bit drn, output bit rdy);
        ifa.in_valid  = v;
        ifa.in_data   = d;
        ifa.in_zext   = z;
        ifa.in_shamt  = s;
        ifa.out_ready = ordy;
        #1;
        rdy = ifa.in_ready;
        acc = ifa.in_valid && ifa.in_ready;
        drn = ifa.out_valid && ifa.out_ready;
        if (drn) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: unexpected result 0x%0h, expected none", tag, ifa.out_data);
            end else begin
                check(tag, 64'(ifa.out_data), 64'(exp_q.pop_front()));
            end
        end
        if (acc) exp_q.push_back(model(32'(d), IN_W, z, int'(s)));
        tick();
    endtask

    task automatic flush_a();
        bit a, d, r;
        for (int k = 0; k < 8; k++) step_a(1'b0, 13'd0, 1'b0, 2'd0, 1'b1, "flush", a, d, r);
        check("flush empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, drn, rdy;
        logic [31:0] dd;
        logic [12:0] bp_vals[3];
        int nxt, ndrain, nstream;

        vecs[0]  = '{1'b0, 32'h1000, 1'b0, 2'd0, 32'hFFFFF000};
        vecs[1]  = '{1'b0, 32'h1FFF, 1'b0, 2'd1, 32'hFFFFFFFE};
        vecs[2]  = '{1'b0, 32'h1FFF, 1'b1, 2'd3, 32'h0000FFF8};
        vecs[3]  = '{1'b0, 32'h0FFF, 1'b1, 2'd0, 32'h00000FFF};
        vecs[4]  = '{1'b0, 32'h0FFF, 1'b0, 2'd3, 32'h00007FF8};
        vecs[5]  = '{1'b0, 32'h1000, 1'b1, 2'd3, 32'h00008000};
        vecs[6]  = '{1'b0, 32'h1ABC, 1'b0, 2'd0, 32'hFFFFFABC};
        vecs[7]  = '{1'b0, 32'h1000, 1'b0, 2'd2, 32'hFFFFC000};
        vecs[8]  = '{1'b1, 32'h80000000, 1'b0, 2'd1, 32'h00000000};
        vecs[9]  = '{1'b1, 32'h7FFFFFFF, 1'b1, 2'd2, 32'hFFFFFFFC};
        vecs[10] = '{1'b1, 32'hC0000001, 1'b0, 2'd3, 32'h00000008};

        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_zext = 1'b0; ifa.in_shamt = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_zext = 1'b0; ifb.in_shamt = '0; ifb.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("reset in_ready", 64'(ifa.in_ready), 64'd0);
        check("reset out_valid", 64'(ifa.out_valid), 64'd0);
        check("reset out_data", 64'(ifa.out_data), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", 64'(ifa.in_ready), 64'd1);
        tick();

        // Directed vectors, one-cycle latency, out_ready held high
        for (int i = 0; i < 11; i++) begin
            dd = vecs[i].data;
            ifa.in_valid = 1'b0;
            ifb.in_valid = 1'b0;
            if (vecs[i].wide) begin
                ifb.in_valid = 1'b1; ifb.in_data = dd; ifb.in_zext = vecs[i].zext; ifb.in_shamt = vecs[i].shamt;
            end else begin
                ifa.in_valid = 1'b1; ifa.in_data = dd[12:0]; ifa.in_zext = vecs[i].zext; ifa.in_shamt = vecs[i].shamt;
            end
            #1;
            check($sformatf("vec%0d in_ready", i),
                  64'(vecs[i].wide ? ifb.in_ready : ifa.in_ready), 64'd1);
            tick();
            check($sformatf("vec%0d out_valid", i),
                  64'(vecs[i].wide ? ifb.out_valid : ifa.out_valid), 64'd1);
            check($sformatf("vec%0d out_data", i),
                  64'(vecs[i].wide ? ifb.out_data : ifa.out_data), 64'(vecs[i].exp));
        end
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        tick();
        check("vec idle out_valid", 64'(ifa.out_valid), 64'd0);

        // Backpressure: 5 stalled cycles while offering 1, 2, 3
        flush_a();
        bp_vals[0] = 13'd1; bp_vals[1] = 13'd2; bp_vals[2] = 13'd3;
        nxt = 0;
        ndrain = 0;
        for (int c = 0; c < 40 && ndrain < 3; c++) begin
            if (c >= 1 && c < 5) begin
                check($sformatf("bp hold valid c%0d", c), 64'(ifa.out_valid), 64'd1);
                check($sformatf("bp hold data c%0d", c), 64'(ifa.out_data), 64'd1);
            end
            step_a(nxt < 3, bp_vals[nxt < 3 ? nxt : 2], 1'b0, 2'd0, c >= 5, "bp order", acc, drn, rdy);
            if (c < 5) check($sformatf("bp in_ready c%0d", c), 64'(rdy), 64'(c < BP_ACCEPTS));
            if (acc) nxt++;
            if (drn) ndrain++;
        end
        check("bp drained count", 64'(ndrain), 64'd3);

        // Reset while a result (and possibly a skid entry) is stalled
        flush_a();
        step_a(1'b1, 13'h0005, 1'b0, 2'd0, 1'b0, "rst pre", acc, drn, rdy);
        step_a(1'b1, 13'h0006, 1'b0, 2'd0, 1'b0, "rst pre", acc, drn, rdy);
        check("rst stalled valid", 64'(ifa.out_valid), 64'd1);
        rst_n = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b0;
        #1;
        check("rst in_ready low", 64'(ifa.in_ready), 64'd0);
        tick();
        check("rst out_valid", 64'(ifa.out_valid), 64'd0);
        check("rst out_data", 64'(ifa.out_data), 64'd0);
        check("rst in_ready during", 64'(ifa.in_ready), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        check("rst in_ready after", 64'(ifa.in_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            step_a(1'b0, 13'd0, 1'b0, 2'd0, 1'b1, "rst discarded", acc, drn, rdy);
            check($sformatf("rst no stale k%0d", k), 64'(drn), 64'd0);
        end

        // Streaming: 64 random requests, one result per cycle
        nstream = 0;
        for (int i = 0; i < 64; i++) begin
            step_a(1'b1, 13'($urandom), 1'($urandom), 2'($urandom), 1'b1, "stream data", acc, drn, rdy);
            check($sformatf("stream accept %0d", i), 64'(acc), 64'd1);
            if (i > 0) check($sformatf("stream b2b %0d", i), 64'(drn), 64'd1);
            if (drn) nstream++;
        end
        step_a(1'b0, 13'd0, 1'b0, 2'd0, 1'b1, "stream data", acc, drn, rdy);
        if (drn) nstream++;
        check("stream result count", 64'(nstream), 64'd64);

        // Random valid/ready traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            step_a($urandom_range(0, 3) != 0, 13'($urandom), 1'($urandom), 2'($urandom),
                   $urandom_range(0, 4) > 1, "random data", acc, drn, rdy);
        end
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            step_a(1'b0, 13'd0, 1'b0, 2'd0, 1'b1, "random data", acc, drn, rdy);
        end
        check("random all delivered", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/signex_pipe.md
SIGNEX_PIPE -- requirements
Module: signex_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 13: width of the input immediate field; legal range 2..OUT_W.
REQ-002 SHALL have parameter OUT_W, default 32: width of the extended result.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data/in_zext/in_shamt carry a request.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a request this cycle.
REQ-007 SHALL have port in_data, input, IN_W bits: raw immediate; bit IN_W-1 is the sign bit.
REQ-008 SHALL have port in_zext, input, 1 bit: 0 = sign-extend, 1 = zero-extend.
REQ-009 SHALL have port in_shamt, input, 2 bits: left shift 0..3 applied after extension.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port out_data, output, OUT_W bits: extended, shifted result.

Function
REQ-013 SHALL compute result = (in_zext ? zero-ext : sign-ext)(in_data to OUT_W) << in_shamt, keeping bits OUT_W-1..0; shifted-out bits dropped, vacated low bits 0.
REQ-014 SHALL transfer input when in_valid && in_ready, output when out_valid && out_ready on the same edge.
REQ-015 SHALL present an accepted request on out_data/out_valid exactly 1 cycle after acceptance when the output register is empty or drains that cycle.
REQ-016 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-017 SHALL deliver results in acceptance order; no request lost or duplicated.
REQ-018 SHALL, when output drains and a new request is accepted on the same edge, load the new result; out_valid stays 1.
REQ-019 SHALL, when output drains with no new request and no buffered entry, clear out_valid.
REQ-020 SHALL ignore in_data/in_zext/in_shamt whenever in_valid is 0 or in_ready is 0.
REQ-021 SHALL produce 1 result per cycle with out_ready held 1 and in_valid held 1.

Reset
REQ-022 SHALL, on any edge with rst_n=0, clear out_valid to 0, out_data to 0 and any buffered entry, regardless of a transfer in progress.
REQ-023 SHALL drive in_ready=0 while rst_n=0 and in_ready=1 on the first cycle after rst_n returns to 1.
REQ-024 SHALL discard a result stalled at reset assertion; it is never delivered.

Configuration
REQ-025 SHALL use macro SIGNEX_PIPE_SKID_EN to select the input buffering.
REQ-026 SHALL, with SIGNEX_PIPE_SKID_EN defined, add one skid entry:
- in_ready is a register output with no combinational path from out_ready.
- A request accepted while the output stalls goes to the skid entry.
- in_ready = 0 while the skid entry is full.
- The skid entry moves to the output on the edge the output drains.
REQ-027 SHALL, without SIGNEX_PIPE_SKID_EN, have no skid entry; in_ready = !out_valid || out_ready, combinational.
REQ-028 SHALL give identical result sequences in both configurations for the same accepted stimulus.

Verification
REQ-029 SHALL cover, with IN_W=13 and OUT_W=32, sign mode:
- in_data=0x1000, shamt=0 -> out_data=0xFFFFF000 one cycle later.
- in_data=0x1FFF, shamt=1 -> out_data=0xFFFFFFFE.
REQ-030 SHALL cover zero mode, IN_W=13, OUT_W=32:
- in_data=0x1FFF, shamt=3 -> out_data=0x0000FFF8.
- in_data=0x0FFF, shamt=0 -> out_data=0x00000FFF.
REQ-031 SHALL cover truncation, IN_W=OUT_W=32: in_data=0x80000000, sign, shamt=1 -> out_data=0x00000000.
REQ-032 SHALL cover backpressure: hold out_ready=0 for 5 cycles while offering 0x0001, 0x0002, 0x0003 (sign, shamt 0); then release.
- out_data held at 0x00000001 during the stall.
- Skid build: in_ready falls after the 2nd accept.
- Non-skid build: in_ready falls after the 1st accept.
- After release, outputs are 1, 2, 3 in order.
REQ-033 SHALL cover reset mid-stall: out_valid=1 with out_ready=0, then rst_n=0 for 1 cycle.
- Next cycle: out_valid=0, out_data=0, in_ready=0 during reset.
- in_ready=1 after reset.
- The stalled result never appears.
REQ-034 SHALL cover streaming: 64 random requests with out_ready=1, all results matching REQ-013, back-to-back, one per cycle.
